uart_xcvr_param: RTL
====================

Name: uart_xcvr_param

Overview:
- Parametrised full-duplex UART transceiver: TX serialiser plus mid-bit-sampling RX deserialiser in one clock domain.
- Successor to the fixed 8N1 UART_top. Adds:
  - configurable data width, parity and stop bits;
  - parity and framing error detection;
  - false-start rejection;
  - internal loopback mode.
- Sits between the byte-level datapath and the external serial pins.

Parameters:
- CLKS_PER_BIT, 24, clk cycles per serial bit. Legal values are ≥ 4; elaboration error otherwise.
- DATA_BITS, 8, payload bits per frame. Legal range 5..9; elaboration error otherwise.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- tx_data  in  DATA_BITS  payload to transmit; captured on accept
- tx_start  in  1  transmit request; accepted in any cycle where tx_start && tx_ready
- tx_ready  out  1  high when the TX FSM is IDLE and can accept
- tx  out  1  serial output; idle high
- rx  in  1  serial input; asynchronous
- loopback  in  1  1 = RX consumes the internal tx signal instead of the rx pin
- rx_data  out  DATA_BITS  last received payload; held until the next rx_valid
- rx_valid  out  1  one-cycle pulse when a frame completes
- rx_parity_err  out  1  parity mismatch on the last frame; updates with rx_valid; 0 when PARITY = 0
- rx_frame_err  out  1  a stop bit sampled low on the last frame; updates with rx_valid

Behaviour:
- Reset: all state and outputs are updated on the clk edge at which srst is sampled high. Values:
  - tx = 1, tx_ready = 1;
  - rx_valid = 0, rx_data = 0, both error flags = 0;
  - TX and RX FSMs to IDLE; bit and baud counters to 0;
  - RX synchroniser flops to 1.
- Reset mid-frame aborts both directions with no rx_valid. tx is high in the cycle after srst.
- Frame format: start(0), DATA_BITS LSB first, optional parity bit, STOP_BITS stop bits(1).
  - N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Parity bit value:
  - odd: XOR of payload, inverted;
  - even: XOR of payload.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE.
  - Accept at cycle T: tx_data is registered and tx_ready = 0 from T+1.
  - tx = 0 over cycles T+1 .. T+CLKS_PER_BIT.
  - The last stop bit ends at cycle T+N*CLKS_PER_BIT.
  - tx_ready = 1 again at T+N*CLKS_PER_BIT+1.
  - With tx_start held high, consecutive frames are separated by exactly one idle-high cycle.
  - tx_start while tx_ready = 0 is ignored, with no queuing. tx_data changes during a frame do not affect it.
- RX input path:
  - Source mux selects rx or tx per loopback.
  - The mux output passes through a 2-flop synchroniser before the FSM.
  - Changing loopback mid-frame is unsupported; the only requirement is no lockup, via the normal IDLE return.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE.
  - IDLE: arm on synchronised line = 0 (falling edge while armed).
  - START: count CLKS_PER_BIT/2 (integer division), then resample.
    - Resample = 1: false start. Return to IDLE with no pulse and no flag change.
    - Otherwise proceed.
  - DATA / PARITY / STOP: each following bit is sampled CLKS_PER_BIT cycles after the previous sample (mid-bit).
  - Data bits shift in LSB first.
  - Parity is compared against the payload XOR per mode.
  - Every stop bit is checked; any low stop bit sets the frame error.
- RX completion:
  - In the cycle after the final stop-bit sample: rx_valid = 1 for one cycle.
  - rx_data and both error flags update in that same cycle and hold afterwards.
- Re-arm rules:
  - After a good frame, RX returns to IDLE and re-arms immediately, since the line is already high.
  - After a frame error with the line still low (break), RX does not re-arm until the synchronised line has been 1 for at least one cycle. No rx_valid is produced during a break.
- TX and RX are fully independent. Simultaneous TX accept and RX completion in one cycle are both honoured.
- Counters:
  - baud counter width = $clog2(CLKS_PER_BIT);
  - bit counter width = $clog2(DATA_BITS+1).
- Loopback latency from TX accept at cycle T: rx_valid occurs at a fixed offset of about T+(N-1)*CLKS_PER_BIT+CLKS_PER_BIT/2+4. The bench measures the offset once and then checks it is constant.

Test Plan:
- Defaults, loopback = 1, tx_data = 0x0C, tx_start pulsed → tx shows bits 0,0,0,1,1,0,0,0,0,1 at 24 cycles each; one rx_valid with rx_data = 0x0C and both error flags 0.
- 20 random bytes, loopback = 1, tx_start held high → 20 rx_valid pulses, in order, all matching; frame starts exactly 241 cycles apart. Repeat with DATA_BITS = 7, STOP_BITS = 2, PARITY = 1.
- PARITY = 2, loopback = 0, bench drives 0xA5 with the parity bit = 1 (wrong; correct even parity is 0) → rx_data = 0xA5, rx_parity_err = 1, rx_frame_err = 0. Then a correct frame → both flags 0.
- Bench drives 0x3C with the stop bit = 0 and holds the line low for 5 bit times → one rx_valid with rx_frame_err = 1, then no further pulses. Line high for 2 bit times, then a valid frame 0x81 → rx_valid, rx_data = 0x81, flags 0.
- rx glitch low for 6 cycles (< 12) → no rx_valid; a following valid frame 0x55 is received correctly.
- srst asserted for 1 cycle during TX data bit 4 → tx = 1 and tx_ready = 1 next cycle, no rx_valid in loopback. The next transmitted 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_xcvr_param.sv
`default_nettype none
// ============================================================================
// uart_xcvr_param : parameterised full-duplex UART transceiver
//                   (TX serialiser + mid-bit-sampling RX, optional loopback)
// Revision        : 1.0
// ============================================================================
module uart_xcvr_param #(
  parameter int CLKS_PER_BIT = 24,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W      = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic              HAS_PARITY = (PARITY != 0);
  localparam logic              ODD_PARITY = (PARITY == 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_xcvr_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_xcvr_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_xcvr_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_xcvr_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- transmit
  state_t               tx_state;
  logic [BAUD_W-1:0]    tx_baud;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_baud_done;

  assign tx_baud_done = (tx_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_state <= ST_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_baud <= (tx_state == ST_IDLE || tx_baud_done) ? '0 : tx_baud + 1'b1;
      case (tx_state)
        ST_IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_PARITY;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_baud_done) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_baud_done) begin
            if (tx_bit == DATA_LAST) begin
              tx_bit <= '0;
              if (HAS_PARITY) begin
                tx       <= tx_par;
                tx_state <= ST_PARITY;
              end else begin
                tx       <= 1'b1;
                tx_state <= ST_STOP;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tx_baud_done) begin
            tx       <= 1'b1;
            tx_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tx_baud_done) begin
            if (tx_bit == STOP_LAST) begin
              tx_ready <= 1'b1;
              tx_state <= ST_IDLE;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  logic                 rx_src;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_armed;
  state_t               rx_state;
  logic [BAUD_W-1:0]    rx_baud;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_baud_done;

  assign rx_src       = loopback ? tx : rx;
  // START waits half a bit to land on mid-bit; later bits are a full bit apart
  assign rx_baud_done = (rx_state == ST_START) ? (rx_baud == HALF_LAST)
                                               : (rx_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_armed      <= 1'b0;
      rx_state      <= ST_IDLE;
      rx_baud       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_perr       <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta  <= rx_src;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      rx_baud  <= (rx_state == ST_IDLE || rx_baud_done) ? '0 : rx_baud + 1'b1;
      case (rx_state)
        ST_IDLE: begin
          rx_armed <= rx_sync;
          if (rx_armed && !rx_sync) begin
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_baud_done) begin
            if (rx_sync) begin
              rx_armed <= 1'b1;
              rx_state <= ST_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_baud_done) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_bit   <= '0;
              rx_state <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (rx_baud_done) begin
            rx_perr  <= rx_sync ^ (^rx_shift) ^ ODD_PARITY;
            rx_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (rx_baud_done) begin
            if (rx_bit == STOP_LAST) begin
              // a low final stop bit (break) keeps RX disarmed until the line rises
              rx_armed      <= rx_sync;
              rx_valid      <= 1'b1;
              rx_data       <= rx_shift;
              rx_parity_err <= HAS_PARITY & rx_perr;
              rx_frame_err  <= rx_ferr | ~rx_sync;
              rx_state      <= ST_IDLE;
            end else begin
              rx_ferr <= rx_ferr | ~rx_sync;
              rx_bit  <= rx_bit + 1'b1;
            end
          end
        end
        default: begin
          rx_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
